// File: rtl/hbridge_gate_driver_if.sv
// Signal bundle between the PWM peripheral, the H-bridge gate driver and the bridge pins.
// Every signal is a plain level sampled on each PCLK edge; there is no valid/ready pairing.
interface hbridge_gate_driver_if;
  logic       PWM_IN;
  logic [1:0] DIR_REQ;
  logic       FAULT_N;
  logic [3:0] GATE;
  logic [1:0] CUR_MODE;
  logic       BUSY;
  logic       FAULT_LATCHED;
  logic       FAULT_IRQ;

  modport master (
    output PWM_IN,
    output DIR_REQ,
    output FAULT_N,
    input  GATE,
    input  CUR_MODE,
    input  BUSY,
    input  FAULT_LATCHED,
    input  FAULT_IRQ
  );

  modport slave (
    input  PWM_IN,
    input  DIR_REQ,
    input  FAULT_N,
    output GATE,
    output CUR_MODE,
    output BUSY,
    output FAULT_LATCHED,
    output FAULT_IRQ
  );
endinterface

// File: rtl/hbridge_gate_driver.sv
// H-bridge gate driver: turns PWM plus a direction request into four gate drives,
// with an all-off dead-time on every mode change and a latched fault shutdown.
module hbridge_gate_driver #(
  parameter int DEAD_CYCLES = 40,
  parameter int CNT_W       = 8
) (
  input  logic                 PCLK,
  input  logic                 PRESETN,
  hbridge_gate_driver_if.slave bus,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    S_COAST = 3'd0,
    S_DEAD  = 3'd1,
    S_FWD   = 3'd2,
    S_REV   = 3'd3,
    S_BRAKE = 3'd4,
    S_FAULT = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] DEAD_RELOAD = CNT_W'(DEAD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_s1_q, fault_s1_d;
  logic             fault_s2_q, fault_s2_d;
  logic [3:0]       gate_q, gate_d;
  logic             irq_q, irq_d;
  logic [1:0]       mode_now;

  function automatic state_e mode_state(input logic [1:0] mode);
    case (mode)
      2'b01:   return S_FWD;
      2'b10:   return S_REV;
      2'b11:   return S_BRAKE;
      default: return S_COAST;
    endcase
  endfunction

  // Mode actually being driven; dead-time and fault both report coast.
  always_comb begin : mode_decode
    mode_now = 2'b00;
    case (state_q)
      S_FWD:   mode_now = 2'b01;
      S_REV:   mode_now = 2'b10;
      S_BRAKE: mode_now = 2'b11;
      default: mode_now = 2'b00;
    endcase
  end

  always_comb begin : sync_next
    fault_s1_d = bus.FAULT_N;
    fault_s2_d = fault_s1_q;
  end

  // Synchronizer comes out of reset reading "no fault".
  always_ff @(posedge PCLK or negedge PRESETN) begin : sync_reg
    if (!PRESETN) begin
      fault_s1_q <= 1'b1;
      fault_s2_q <= 1'b1;
    end else begin
      fault_s1_q <= fault_s1_d;
      fault_s2_q <= fault_s2_d;
    end
  end

  always_comb begin : fsm_next
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    irq_d    = 1'b0;
    if (!fault_s2_q) begin
      // Fault outranks any pending request or dead-time expiry.
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_FAULT: begin
          if (bus.DIR_REQ == 2'b00) begin
            state_d  = S_DEAD;
            target_d = 2'b00;
            cnt_d    = DEAD_RELOAD;
          end
        end
        S_DEAD: begin
          if (bus.DIR_REQ != target_q) begin
            target_d = bus.DIR_REQ;
            cnt_d    = DEAD_RELOAD;
          end else if (cnt_q == '0) begin
            state_d = mode_state(target_q);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          if (bus.DIR_REQ != mode_now) begin
            state_d  = S_DEAD;
            target_d = bus.DIR_REQ;
            cnt_d    = DEAD_RELOAD;
          end
        end
      endcase
    end
    irq_d = (state_d == S_FAULT) && (state_q != S_FAULT);
  end

  // A low synchronized fault kills the gates on the same edge the FSM enters FAULT.
  always_comb begin : gate_next
    gate_d = 4'b0000;
    if (fault_s2_q) begin
      case (state_q)
        S_FWD:   gate_d = {1'b1, 1'b0, 1'b0, bus.PWM_IN};
        S_REV:   gate_d = {1'b0, bus.PWM_IN, 1'b1, 1'b0};
        S_BRAKE: gate_d = 4'b1010;
        default: gate_d = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin : fsm_reg
    if (!PRESETN) begin
      state_q  <= S_COAST;
      target_q <= 2'b00;
      cnt_q    <= '0;
      gate_q   <= 4'b0000;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      gate_q   <= gate_d;
      irq_q    <= irq_d;
    end
  end

  assign bus.GATE          = gate_q;
  assign bus.CUR_MODE      = mode_now;
  assign bus.BUSY          = (state_q == S_DEAD);
  assign bus.FAULT_LATCHED = (state_q == S_FAULT);
  assign bus.FAULT_IRQ     = irq_q;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_hbridge_gate_driver.sv
// Bench for hbridge_gate_driver: directed scenarios plus randomized traffic,
// checked against a mode-level reference model of the driver.
module tb_hbridge_gate_driver;
  localparam int DEAD    = 40;
  localparam int M_FAULT = -1;
  localparam int M_DEAD  = -2;

  logic       PCLK    = 1'b0;
  logic       PRESETN = 1'b0;
  logic       clk_en  = 1'b1;
  logic [2:0] state_dbg;
  logic [8:0] dut_out;
  int         n_pass  = 0;
  int         n_total = 0;

  hbridge_gate_driver_if bus();

  hbridge_gate_driver #(.DEAD_CYCLES(DEAD), .CNT_W(8)) dut (
    .PCLK      (PCLK),
    .PRESETN   (PRESETN),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  assign dut_out = {bus.GATE, bus.CUR_MODE, bus.BUSY, bus.FAULT_LATCHED, bus.FAULT_IRQ};

  // ---------------- clock / reset ----------------
  always begin
    #5;
    if (clk_en) PCLK = ~PCLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // mode: 0..3 = driven mode (DIR encoding), M_DEAD, M_FAULT
  typedef struct {
    int         mode;
    int         tgt;
    int         left;
    logic       s1;
    logic       s2;
    logic       irq;
    logic [3:0] gate;
  } model_t;

  model_t m;

  function automatic logic [3:0] drive_of(int mode, logic pwm);
    case (mode)
      1:       return {3'b100, pwm};
      2:       return {1'b0, pwm, 2'b10};
      3:       return 4'b1010;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic model_t model_reset();
    model_t r;
    r.mode = 0; r.tgt = 0; r.left = 0;
    r.s1 = 1'b1; r.s2 = 1'b1; r.irq = 1'b0; r.gate = 4'b0000;
    return r;
  endfunction

  function automatic model_t model_next(model_t c, logic [1:0] dir, logic pwm, logic fpin);
    model_t n;
    n      = c;
    n.irq  = 1'b0;
    n.gate = c.s2 ? drive_of(c.mode, pwm) : 4'b0000;
    if (!c.s2) begin
      n.mode = M_FAULT;
      n.irq  = (c.mode != M_FAULT);
    end else if (c.mode == M_FAULT) begin
      if (dir == 2'b00) begin n.mode = M_DEAD; n.tgt = 0; n.left = DEAD; end
    end else if (c.mode == M_DEAD) begin
      if (int'(dir) != c.tgt) begin
        n.tgt = int'(dir); n.left = DEAD;
      end else begin
        n.left = c.left - 1;
        if (n.left == 0) n.mode = c.tgt;
      end
    end else if (int'(dir) != c.mode) begin
      n.mode = M_DEAD; n.tgt = int'(dir); n.left = DEAD;
    end
    n.s1 = fpin;
    n.s2 = c.s1;
    return n;
  endfunction

  function automatic logic [8:0] exp_out(model_t c);
    logic [1:0] cm;
    cm = (c.mode >= 0) ? 2'(c.mode) : 2'b00;
    return {c.gate, cm, c.mode == M_DEAD, c.mode == M_FAULT, c.irq};
  endfunction

  always @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) m <= model_reset();
    else          m <= model_next(m, bus.DIR_REQ, bus.PWM_IN, bus.FAULT_N);
  end

  always @(negedge PCLK) begin
    if (PRESETN)
      assert (!(bus.GATE[0] && bus.GATE[1]) && !(bus.GATE[2] && bus.GATE[3]))
        else $error("FAIL gate_invariant GATE=%b", bus.GATE);
  end

  // ---------------- driver ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.DIR_REQ = 2'b00; bus.PWM_IN = 1'b0; bus.FAULT_N = 1'b1;
    PRESETN = 1'b0;
    #12;
    n_total++;
    if (dut_out !== 9'b0) $display("FAIL reset_outputs: got %b expected %b", dut_out, 9'b0);
    else n_pass++;
    @(negedge PCLK);
    PRESETN = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.PWM_IN = 1'($urandom_range(0, 1));
      tick(1);
      n_total++;
      if (dut_out !== 9'b0) $display("FAIL reset_coast k=%0d: got %b expected %b", k, dut_out, 9'b0);
      else n_pass++;
    end
  endtask

  task automatic test_forward();
    int   busy_cnt;
    int   first_fwd;
    logic v;
    busy_cnt = 0; first_fwd = -1;
    bus.DIR_REQ = 2'b01;
    for (int k = 1; k <= 60; k++) begin
      v = 1'($urandom_range(0, 1));
      bus.PWM_IN = v;
      tick(1);
      busy_cnt += int'(bus.BUSY);
      if (first_fwd < 0 && bus.CUR_MODE == 2'b01) first_fwd = k;
      n_total++;
      if (k <= 41 && bus.GATE !== 4'b0000)
        $display("FAIL fwd_deadtime_gate k=%0d: got %b expected 0000", k, bus.GATE);
      else if (k > 41 && bus.GATE !== {3'b100, v})
        $display("FAIL fwd_gate k=%0d: got %b expected %b", k, bus.GATE, {3'b100, v});
      else n_pass++;
      n_total++;
      if (dut_out !== exp_out(m)) $display("FAIL fwd_model k=%0d: got %b expected %b", k, dut_out, exp_out(m));
      else n_pass++;
    end
    n_total++;
    if (busy_cnt != DEAD) $display("FAIL fwd_busy_cycles: got %0d expected %0d", busy_cnt, DEAD);
    else n_pass++;
    n_total++;
    if (first_fwd != DEAD + 1) $display("FAIL fwd_entry_cycle: got %0d expected %0d", first_fwd, DEAD + 1);
    else n_pass++;
  endtask

  task automatic test_restart();
    int first_mode;
    int first_gate;
    first_mode = -1; first_gate = -1;
    bus.DIR_REQ = 2'b10;
    tick(20);
    n_total++;
    if ({bus.BUSY, bus.CUR_MODE} !== 3'b100) $display("FAIL restart_mid_dead: got %b expected 100", {bus.BUSY, bus.CUR_MODE});
    else n_pass++;
    bus.DIR_REQ = 2'b11;
    for (int k = 1; k <= 60; k++) begin
      bus.PWM_IN = 1'($urandom_range(0, 1));
      tick(1);
      if (first_mode < 0 && bus.CUR_MODE == 2'b11) first_mode = k;
      if (first_gate < 0 && bus.GATE == 4'b1010) first_gate = k;
      n_total++;
      if (dut_out !== exp_out(m)) $display("FAIL restart_model k=%0d: got %b expected %b", k, dut_out, exp_out(m));
      else n_pass++;
    end
    n_total++;
    if (first_mode != DEAD + 1) $display("FAIL restart_brake_mode: got %0d expected %0d", first_mode, DEAD + 1);
    else n_pass++;
    n_total++;
    if (first_gate != DEAD + 2) $display("FAIL restart_brake_gate: got %0d expected %0d", first_gate, DEAD + 2);
    else n_pass++;
  endtask

  task automatic test_fault();
    int busy_cnt;
    bus.DIR_REQ = 2'b10;
    bus.PWM_IN  = 1'b1;
    tick(45);
    n_total++;
    if (bus.CUR_MODE !== 2'b10) $display("FAIL fault_in_rev: got %b expected 10", bus.CUR_MODE);
    else n_pass++;
    #2 bus.FAULT_N = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      n_total++;
      if (k < 3 && {bus.FAULT_LATCHED, bus.FAULT_IRQ} !== 2'b00)
        $display("FAIL fault_early k=%0d: got %b expected 00", k, {bus.FAULT_LATCHED, bus.FAULT_IRQ});
      else if (k == 3 && {bus.GATE, bus.FAULT_LATCHED, bus.FAULT_IRQ} !== 6'b000011)
        $display("FAIL fault_entry: got %b expected 000011", {bus.GATE, bus.FAULT_LATCHED, bus.FAULT_IRQ});
      else if (k > 3 && {bus.GATE, bus.FAULT_LATCHED, bus.FAULT_IRQ} !== 6'b000010)
        $display("FAIL fault_hold k=%0d: got %b expected 000010", k, {bus.GATE, bus.FAULT_LATCHED, bus.FAULT_IRQ});
      else n_pass++;
      n_total++;
      if (dut_out !== exp_out(m)) $display("FAIL fault_model k=%0d: got %b expected %b", k, dut_out, exp_out(m));
      else n_pass++;
    end
    bus.FAULT_N = 1'b1;
    tick(10);
    n_total++;
    if (bus.FAULT_LATCHED !== 1'b1) $display("FAIL fault_sticky_dir: got %b expected 1", bus.FAULT_LATCHED);
    else n_pass++;
    bus.DIR_REQ = 2'b00;
    busy_cnt = 0;
    for (int k = 1; k <= 45; k++) begin
      tick(1);
      busy_cnt += int'(bus.BUSY);
      n_total++;
      if (dut_out !== exp_out(m)) $display("FAIL fault_exit_model k=%0d: got %b expected %b", k, dut_out, exp_out(m));
      else n_pass++;
    end
    n_total++;
    if (busy_cnt != DEAD) $display("FAIL fault_exit_dead: got %0d expected %0d", busy_cnt, DEAD);
    else n_pass++;
    n_total++;
    if (dut_out !== 9'b0) $display("FAIL fault_exit_coast: got %b expected %b", dut_out, 9'b0);
    else n_pass++;
  endtask

  task automatic test_fault_at_expiry();
    logic drove;
    drove = 1'b0;
    bus.DIR_REQ = 2'b01;
    for (int k = 1; k <= 50; k++) begin
      bus.PWM_IN = 1'($urandom_range(0, 1));
      tick(1);
      if (bus.CUR_MODE == 2'b01 || bus.GATE != 4'b0000) drove = 1'b1;
      if (k == 38) bus.FAULT_N = 1'b0;
      if (k == 40) begin
        n_total++;
        if (bus.BUSY !== 1'b1) $display("FAIL expiry_still_dead: got %b expected 1", bus.BUSY);
        else n_pass++;
      end
      if (k == 41) begin
        n_total++;
        if ({bus.FAULT_LATCHED, bus.FAULT_IRQ} !== 2'b11) $display("FAIL expiry_fault_entry: got %b expected 11", {bus.FAULT_LATCHED, bus.FAULT_IRQ});
        else n_pass++;
      end
      n_total++;
      if (dut_out !== exp_out(m)) $display("FAIL expiry_model k=%0d: got %b expected %b", k, dut_out, exp_out(m));
      else n_pass++;
    end
    n_total++;
    if (drove !== 1'b0) $display("FAIL expiry_target_driven: got %b expected 0", drove);
    else n_pass++;
    bus.FAULT_N = 1'b1;
    bus.DIR_REQ = 2'b00;
    tick(45);
    n_total++;
    if (dut_out !== 9'b0) $display("FAIL expiry_recover: got %b expected %b", dut_out, 9'b0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_dead();
    bus.DIR_REQ = 2'b11;
    tick(45);
    n_total++;
    if (bus.GATE !== 4'b1010) $display("FAIL rst_brake_gate: got %b expected 1010", bus.GATE);
    else n_pass++;
    bus.DIR_REQ = 2'b01;
    tick(1);
    n_total++;
    if ({bus.BUSY, bus.GATE} !== 5'b11010) $display("FAIL rst_pre_dead: got %b expected 11010", {bus.BUSY, bus.GATE});
    else n_pass++;
    clk_en = 1'b0;
    #3 PRESETN = 1'b0;
    #1;
    n_total++;
    if (dut_out !== 9'b0) $display("FAIL rst_async_clear: got %b expected %b", dut_out, 9'b0);
    else n_pass++;
    #20;
    bus.DIR_REQ = 2'b00;
    PRESETN = 1'b1;
    #2 clk_en = 1'b1;
    @(negedge PCLK);
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      n_total++;
      if (dut_out !== 9'b0) $display("FAIL rst_release_coast k=%0d: got %b expected %b", k, dut_out, 9'b0);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int fault_hold;
    fault_hold = 0;
    for (int k = 0; k < 1500; k++) begin
      bus.PWM_IN = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) bus.DIR_REQ = 2'($urandom_range(0, 3));
      if (fault_hold > 0) fault_hold--;
      else if ($urandom_range(0, 199) == 0) fault_hold = $urandom_range(1, 6);
      bus.FAULT_N = (fault_hold == 0);
      tick(1);
      n_total++;
      if (dut_out !== exp_out(m)) $display("FAIL random_model k=%0d: got %b expected %b", k, dut_out, exp_out(m));
      else n_pass++;
      n_total++;
      if ((bus.GATE[0] & bus.GATE[1]) | (bus.GATE[2] & bus.GATE[3]))
        $display("FAIL random_shoot_through k=%0d: got GATE=%b required no leg 11", k, bus.GATE);
      else n_pass++;
    end
    bus.FAULT_N = 1'b1;
    bus.DIR_REQ = 2'b00;
    tick(50);
    n_total++;
    if (dut_out !== 9'b0) $display("FAIL random_settle: got %b expected %b", dut_out, 9'b0);
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.PWM_IN  = 1'b0;
    bus.DIR_REQ = 2'b00;
    bus.FAULT_N = 1'b1;
    test_reset();
    test_forward();
    test_restart();
    test_fault();
    test_fault_at_expiry();
    test_reset_mid_dead();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
